riscorvo_dbus_bridge: RTL and testbench

Bridges the riscorvo core's data-memory port (valid/ready, addr, write data, read/write, byte mask) onto the request/grant/response data bus of the memory fabric. It holds one transaction in flight and registers all outputs. It converts bus errors and missing responses into a defined error completion, so the core never hangs on a silent target. It sits directly downstream of `riscorvo_top`'s `*_data_*` signals.

---
 rtl/riscorvo_pkg.sv | 21 ++
 rtl/riscorvo_dbus_bridge.sv | 132 +++++++++++++
 tb/tb_riscorvo_dbus_bridge.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscorvo_pkg.sv
// Shared types for the riscorvo data-bus bridge: FSM states, latched request
// and the default error read-back pattern.
package riscorvo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } dbus_state_t;

  localparam logic [31:0] DBUS_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } dbus_req_t;

endpackage

// File: rtl/riscorvo_dbus_bridge.sv
// Core data-port (valid/ready) to fabric req/gnt/rvalid bridge, one transaction
// in flight, registered outputs, timeout and bus errors mapped to error completions.
module riscorvo_dbus_bridge
  import riscorvo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = DBUS_ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_data_i,
  input  logic [31:0] addr_data_i,
  input  logic [31:0] write_data_i,
  input  logic        read_write_i,
  input  logic [3:0]  mask_data_i,
  output logic        ready_data_o,
  output logic [31:0] read_data_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        bus_error_o,
  output logic [31:0] err_addr_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  dbus_state_t state_q, state_d;
  dbus_req_t   req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        stale_q, stale_d;
  logic        ready_d, req_d_o, berr_d;
  logic [31:0] rdata_d, eaddr_d;
  logic        timeout, rsp_live;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    stale_d  = stale_q && !rvalid_i;   // first response after a timeout is discarded
    ready_d  = 1'b0;
    berr_d   = 1'b0;
    rdata_d  = read_data_o;
    eaddr_d  = err_addr_o;
    timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == TMAX);
    rsp_live = rvalid_i && !stale_q;

    if ((state_q == REQ || state_q == RSP) && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (valid_data_i) begin
          if (mask_data_i != 4'h0) begin
            req_d.addr  = addr_data_i;
            req_d.wdata = write_data_i;
            req_d.we    = read_write_i;
            req_d.be    = mask_data_i;
            cnt_d       = '0;
            state_d     = REQ;
          end else begin
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (gnt_i) begin
          state_d = RSP;
        end else if (timeout) begin
          state_d = DONE;
          berr_d  = 1'b1;
        end
      end
      RSP: begin
        if (rsp_live) begin
          state_d = DONE;
          if (err_i) berr_d = 1'b1;
          else       rdata_d = req_q.we ? 32'h0 : rdata_i;
        end else if (timeout) begin
          state_d = DONE;
          berr_d  = 1'b1;
          stale_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (berr_d) begin
      rdata_d = ERR_DATA;
      eaddr_d = req_q.addr;
    end
    ready_d = (state_d == DONE);
    req_d_o = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      stale_q      <= 1'b0;
      ready_data_o <= 1'b0;
      read_data_o  <= '0;
      req_o        <= 1'b0;
      bus_error_o  <= 1'b0;
      err_addr_o   <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      stale_q      <= stale_d;
      ready_data_o <= ready_d;
      read_data_o  <= rdata_d;
      req_o        <= req_d_o;
      bus_error_o  <= berr_d;
      err_addr_o   <= eaddr_d;
    end
  end

  assign addr_o  = {req_q.addr[31:2], 2'b00};
  assign we_o    = req_q.we;
  assign be_o    = req_q.be;
  assign wdata_o = req_q.wdata;

endmodule

// File: tb/tb_riscorvo_dbus_bridge.sv
// Scoreboarded bench for riscorvo_dbus_bridge with a short timeout.
module tb_riscorvo_dbus_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_data_i;
  logic [31:0] addr_data_i, write_data_i;
  logic        read_write_i;
  logic [3:0]  mask_data_i;
  logic        ready_data_o;
  logic [31:0] read_data_o;
  logic        req_o, gnt_i;
  logic [31:0] addr_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        err_i;
  logic        bus_error_o;
  logic [31:0] err_addr_o;

  riscorvo_dbus_bridge #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset_n(reset_n),
    .valid_data_i(valid_data_i), .addr_data_i(addr_data_i),
    .write_data_i(write_data_i), .read_write_i(read_write_i),
    .mask_data_i(mask_data_i), .ready_data_o(ready_data_o),
    .read_data_o(read_data_o), .req_o(req_o), .gnt_i(gnt_i),
    .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i),
    .bus_error_o(bus_error_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] eaddr;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_eaddr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic e, input logic [31:0] a);
    exp_t x;
    if (e) exp_eaddr = a;
    x.rdata = d;
    x.err   = e;
    x.eaddr = exp_eaddr;
    sb.push_back(x);
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic we,
                           input logic [3:0] m);
    valid_data_i = 1'b1;
    addr_data_i  = a;
    write_data_i = d;
    read_write_i = we;
    mask_data_i  = m;
  endtask

  // Completion monitor: every ready pulse must match the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus_error_o && !ready_data_o) chk("berr_without_ready", 32'(bus_error_o), 32'h0);
      if (ready_data_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'(ready_data_o), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("read_data", read_data_o, e.rdata);
          chk("bus_error", 32'(bus_error_o), 32'(e.err));
          chk("err_addr", err_addr_o, e.eaddr);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    valid_data_i = 1'b0; addr_data_i = '0; write_data_i = '0;
    read_write_i = 1'b0; mask_data_i = '0;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(ready_data_o), 32'h0);
    chk("rst_req", 32'(req_o), 32'h0);
    chk("rst_rdata", read_data_o, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_be", 32'(be_o), 32'h0);
    chk("rst_erraddr", err_addr_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Zero-wait read
    drive_req(32'h100, 32'h0, 1'b0, 4'hF);
    push(32'h1234_5678, 1'b0, 32'h0);
    tick();                                     // cycle 1
    chk("zw_req_c1", 32'(req_o), 32'h1);
    chk("zw_addr", addr_o, 32'h100);
    chk("zw_be", 32'(be_o), 32'hF);
    chk("zw_we", 32'(we_o), 32'h0);
    gnt_i = 1'b1;
    tick();                                     // cycle 2
    chk("zw_req_c2", 32'(req_o), 32'h0);
    chk("zw_ready_c2", 32'(ready_data_o), 32'h0);
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
    tick();                                     // cycle 3
    chk("zw_ready_c3", 32'(ready_data_o), 32'h1);
    rvalid_i = 1'b0; valid_data_i = 1'b0;
    tick();
    chk("zw_ready_c4", 32'(ready_data_o), 32'h0);

    // Write, grant in 4th request cycle; response lands on the timeout count
    drive_req(32'h203, 32'hAA00_0000, 1'b1, 4'b1000);
    push(32'h0, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("wr_req_held", 32'(req_o), 32'h1);
      if (i == 1) begin
        chk("wr_addr", addr_o, 32'h200);
        chk("wr_be", 32'(be_o), 32'h8);
        chk("wr_we", 32'(we_o), 32'h1);
        chk("wr_wdata", wdata_o, 32'hAA00_0000);
      end
      if (i == 4) gnt_i = 1'b1;
    end
    tick();
    chk("wr_req_drop", 32'(req_o), 32'h0);
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h5555_5555;
    tick();
    chk("wr_ready", 32'(ready_data_o), 32'h1);
    rvalid_i = 1'b0; valid_data_i = 1'b0;
    tick();
    chk("wr_single_pulse", 32'(ready_data_o), 32'h0);

    // Error response
    drive_req(32'h40, 32'h0, 1'b0, 4'hF);
    push(32'hDEAD_BEEF, 1'b1, 32'h40);
    tick(); gnt_i = 1'b1;
    tick(); gnt_i = 1'b0; rvalid_i = 1'b1; err_i = 1'b1;
    tick();
    chk("er_ready", 32'(ready_data_o), 32'h1);
    rvalid_i = 1'b0; err_i = 1'b0; valid_data_i = 1'b0;
    tick();
    chk("er_berr_pulse", 32'(bus_error_o), 32'h0);
    chk("er_addr_hold", err_addr_o, 32'h40);

    // RSP timeout then stale response discarded
    drive_req(32'h80, 32'h0, 1'b0, 4'hF);
    push(32'hDEAD_BEEF, 1'b1, 32'h80);
    tick(); gnt_i = 1'b1;                       // cycle 1, enter REQ
    tick(); gnt_i = 1'b0;                       // cycle 2
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk("to_no_ready", 32'(ready_data_o), 32'h0);
    end
    tick();                                     // cycle 6
    chk("to_ready", 32'(ready_data_o), 32'h1);
    chk("to_berr", 32'(bus_error_o), 32'h1);
    valid_data_i = 1'b0;
    tick();
    chk("to_stale_set", 32'(dut.stale_q), 32'h1);
    drive_req(32'hC0, 32'h0, 1'b0, 4'hF);
    push(32'h2222, 1'b0, 32'h0);
    tick();
    chk("st_req", 32'(req_o), 32'h1);
    gnt_i = 1'b1;
    tick(); gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1111;
    tick(); rdata_i = 32'h2222;
    chk("st_stale_clr", 32'(dut.stale_q), 32'h0);
    chk("st_no_early_ready", 32'(ready_data_o), 32'h0);
    tick();
    chk("st_ready", 32'(ready_data_o), 32'h1);
    rvalid_i = 1'b0; valid_data_i = 1'b0;
    tick();

    // Zero mask, then back-to-back request
    drive_req(32'h300, 32'h0, 1'b0, 4'h0);
    push(32'h0, 1'b0, 32'h0);
    tick();
    chk("zm_ready", 32'(ready_data_o), 32'h1);
    chk("zm_no_req", 32'(req_o), 32'h0);
    drive_req(32'h304, 32'h0, 1'b0, 4'hF);
    push(32'hCAFE_F00D, 1'b0, 32'h0);
    tick();
    chk("bb_idle_req", 32'(req_o), 32'h0);
    tick();
    chk("bb_req", 32'(req_o), 32'h1);
    chk("bb_addr", addr_o, 32'h304);
    gnt_i = 1'b1;
    tick(); gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hCAFE_F00D;
    tick();
    chk("bb_ready", 32'(ready_data_o), 32'h1);
    rvalid_i = 1'b0; valid_data_i = 1'b0;
    tick();

    // Reset while waiting for the response
    drive_req(32'h500, 32'h0, 1'b0, 4'h3);
    tick(); gnt_i = 1'b1;
    tick(); gnt_i = 1'b0;
    #2 reset_n = 1'b0;
    exp_eaddr = 32'h0;
    #1;
    chk("mr_req", 32'(req_o), 32'h0);
    chk("mr_ready", 32'(ready_data_o), 32'h0);
    chk("mr_addr", addr_o, 32'h0);
    chk("mr_be", 32'(be_o), 32'h0);
    chk("mr_erraddr", err_addr_o, 32'h0);
    chk("mr_stale", 32'(dut.stale_q), 32'h0);
    valid_data_i = 1'b0;
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    rvalid_i = 1'b1; rdata_i = 32'h9999;
    tick();
    rvalid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mr_no_ready", 32'(ready_data_o), 32'h0);
    end

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
